register_file: RTL and testbench

// - General-purpose register file for the MIPS pipeline: 2**AWIDTH x DWIDTH storage.
// - One synchronous write port (WB stage), two asynchronous read ports (ID stage: rs, rt).
// - Register 0 is hardwired to zero (MIPS $zero).
// - Same-cycle write-to-read bypass, so WB and ID may overlap without a hazard.

---
 rtl/register_file_pkg.sv | 6 +
 rtl/register_file_read_port.sv | 20 ++
 rtl/register_file.sv | 44 ++++
 tb/tb_register_file.sv | 131 +++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths and the hardwired-zero register address
package register_file_pkg;
    localparam int DWIDTH_DEF = 32;
    localparam int AWIDTH_DEF = 5;
    localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/register_file_read_port.sv
// regfile_read_port: combinational read mux with same-cycle write bypass
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] row,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    output logic [DWIDTH-1:0] data
);
    logic is_zero;
    logic hit;
    assign is_zero = addr == AWIDTH'(REG_ZERO);
    assign hit     = wr_en && !is_zero && wr_addr == addr;
    assign data    = hit ? wr_data : is_zero ? '0 : row;
endmodule

// File: rtl/register_file.sv
// register_file: 2**AWIDTH x DWIDTH MIPS register file, $zero hardwired, write-to-read bypass
module register_file
    import register_file_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_wr_en,
    input  logic [AWIDTH-1:0] r_addr_in,
    input  logic [DWIDTH-1:0] r_data_in,
    input  logic [AWIDTH-1:0] r_addr_out1,
    output logic [DWIDTH-1:0] r_data_out1,
    input  logic [AWIDTH-1:0] r_addr_out2,
    output logic [DWIDTH-1:0] r_data_out2
);
    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic              wr_act;
    // gating with r_rst keeps the bypass from leaking data while held in reset
    assign wr_act = r_wr_en && r_rst;
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst)
            mem_q <= '{default: '0};
        else if (r_wr_en && r_addr_in != AWIDTH'(REG_ZERO))
            mem_q[r_addr_in] <= r_data_in;
    end
    regfile_read_port #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_rd1 (
        .addr    (r_addr_out1),
        .row     (mem_q[r_addr_out1]),
        .wr_en   (wr_act),
        .wr_addr (r_addr_in),
        .wr_data (r_data_in),
        .data    (r_data_out1)
    );
    regfile_read_port #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_rd2 (
        .addr    (r_addr_out2),
        .row     (mem_q[r_addr_out2]),
        .wr_en   (wr_act),
        .wr_addr (r_addr_in),
        .wr_data (r_data_in),
        .data    (r_data_out2)
    );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vectors with hand-computed expectations for register_file
module tb_register_file;
    logic        r_clk = 1'b0;
    logic        r_rst = 1'b0;
    logic        r_wr_en = 1'b0;
    logic [4:0]  r_addr_in = '0;
    logic [31:0] r_data_in = '0;
    logic [4:0]  r_addr_out1 = '0;
    logic [4:0]  r_addr_out2 = '0;
    logic [31:0] r_data_out1;
    logic [31:0] r_data_out2;
    int n_vec = 0;
    int n_err = 0;

    register_file dut (
        .r_clk       (r_clk),
        .r_rst       (r_rst),
        .r_wr_en     (r_wr_en),
        .r_addr_in   (r_addr_in),
        .r_data_in   (r_data_in),
        .r_addr_out1 (r_addr_out1),
        .r_data_out1 (r_data_out1),
        .r_addr_out2 (r_addr_out2),
        .r_data_out2 (r_data_out2)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge r_clk);
        r_wr_en = 1'b1;
        r_addr_in = a;
        r_data_in = d;
        @(posedge r_clk);
        #1;
        r_wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        r_addr_out1 = a;
        r_addr_out2 = a;
        #1;
        check({tag, "_p1"}, r_data_out1, exp);
        check({tag, "_p2"}, r_data_out2, exp);
    endtask

    initial begin
        // held in reset: even an attempted bypass must read 0
        r_wr_en = 1'b1;
        r_addr_in = 5'd4;
        r_data_in = 32'hFFFF_FFFF;
        r_addr_out1 = 5'd4;
        r_addr_out2 = 5'd4;
        repeat (2) @(posedge r_clk);
        #1;
        check("rst_bypass_p1", r_data_out1, 32'h0);
        check("rst_bypass_p2", r_data_out2, 32'h0);
        r_wr_en = 1'b0;
        @(negedge r_clk);
        r_rst = 1'b1;
        for (int i = 0; i < 32; i++) rd("reset", 5'(i), 32'h0);

        for (int i = 0; i < 10; i++) wr(5'(i), 32'(i));
        for (int i = 0; i < 10; i++) rd("sweep", 5'(i), 32'(i));
        rd("untouched", 5'd20, 32'h0);

        wr(5'd0, 32'hDEAD_BEEF);
        rd("zero_dead", 5'd0, 32'h0);
        wr(5'd0, 'x);
        rd("zero_x", 5'd0, 32'h0);
        @(negedge r_clk);
        r_wr_en = 1'b1;
        r_addr_in = 5'd0;
        r_data_in = 32'hDEAD_BEEF;
        r_addr_out1 = 5'd0;
        #1;
        check("zero_nobypass", r_data_out1, 32'h0);
        r_wr_en = 1'b0;

        @(negedge r_clk);
        r_addr_in = 5'd5;
        r_data_in = 32'h1234;
        @(posedge r_clk);
        #1;
        rd("wr_dis", 5'd5, 32'd5);

        @(negedge r_clk);
        r_wr_en = 1'b1;
        r_addr_in = 5'd7;
        r_data_in = 32'hA5A5_A5A5;
        r_addr_out1 = 5'd7;
        r_addr_out2 = 5'd3;
        #1;
        check("byp_p1", r_data_out1, 32'hA5A5_A5A5);
        check("byp_other_p2", r_data_out2, 32'd3);
        r_addr_out2 = 5'd7;
        #1;
        check("byp_both_p2", r_data_out2, 32'hA5A5_A5A5);
        @(posedge r_clk);
        #1;
        r_wr_en = 1'b0;
        #1;
        check("after_byp_p1", r_data_out1, 32'hA5A5_A5A5);
        rd("neighbour", 5'd6, 32'd6);
        rd("last_sweep", 5'd9, 32'd9);

        // drop reset mid-phase, well clear of either clock edge
        r_addr_out1 = 5'd7;
        r_addr_out2 = 5'd9;
        @(posedge r_clk);
        #2;
        r_rst = 1'b0;
        #1;
        check("async_rst_p1", r_data_out1, 32'h0);
        check("async_rst_p2", r_data_out2, 32'h0);
        @(negedge r_clk);
        r_rst = 1'b1;
        for (int i = 0; i < 32; i++) rd("post_rst", 5'(i), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
